// File: rtl/boot_uart_ctrl_pkg.sv
// Common definitions for the boot sequencer and UART TX arbiter.
package boot_uart_ctrl_pkg;

    typedef enum logic [1:0] {
        POR_WAIT = 2'd0,
        RUN      = 2'd1,
        HOLD     = 2'd2
    } boot_state_t;

    localparam int TX_SRC_CPU = 0;
    localparam int TX_SRC_OCD = 1;

    localparam logic [31:0] DEFAULT_START_ADDR = 32'h8000_0000;
    localparam logic [31:0] DEFAULT_STACK_ADDR = 32'h8000_FFF0;

endpackage

// File: rtl/uart_tx_arbiter.sv
// N-source TX mux that only changes source after the current line has been
// idle-high long enough to be sure no frame is in flight.
module uart_tx_arbiter #(
    parameter int NUM_TX_SRC = 2,
    parameter int SEL_W      = 1,
    parameter int IDLE_GUARD = 1000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [SEL_W-1:0]      tx_sel,
    input  logic [NUM_TX_SRC-1:0] tx_in,
    output logic                  txd,
    output logic [SEL_W-1:0]      active_sel
);

    localparam int CNT_W = $clog2(IDLE_GUARD + 1);
    localparam logic [CNT_W-1:0] GUARD     = CNT_W'(IDLE_GUARD);
    localparam logic [SEL_W:0]   SRC_LIMIT = (SEL_W + 1)'(NUM_TX_SRC);

    logic [CNT_W-1:0] idle_cnt;
    logic             cur_line;
    logic             switch_ok;

    assign cur_line  = tx_in[active_sel];
    // Out-of-range selects are ignored rather than clamped.
    assign switch_ok = (tx_sel != active_sel)
                    && ({1'b0, tx_sel} < SRC_LIMIT)
                    && (idle_cnt == GUARD);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            txd        <= 1'b1;
            active_sel <= '0;
            idle_cnt   <= '0;
        end else begin
            txd <= cur_line;
            if (switch_ok) begin
                active_sel <= tx_sel;
                idle_cnt   <= '0;
            end else if (!cur_line) begin
                idle_cnt <= '0;
            end else if (idle_cnt != GUARD) begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/boot_uart_ctrl.sv
// CPU start sequencer (power-on and OCD starts, reset gating) plus the
// guarded UART TX source arbiter between the OCD and the MCU core.
module boot_uart_ctrl
    import boot_uart_ctrl_pkg::*;
#(
    parameter int              NUM_TX_SRC         = 2,
    parameter int              SEL_W              = 1,
    parameter int              XLEN               = 32,
    parameter logic [XLEN-1:0] DEFAULT_START_ADDR = boot_uart_ctrl_pkg::DEFAULT_START_ADDR,
    parameter logic [XLEN-1:0] DEFAULT_STACK_ADDR = boot_uart_ctrl_pkg::DEFAULT_STACK_ADDR,
    parameter int              POR_DELAY          = 4,
    parameter int              IDLE_GUARD         = 1000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cpu_reset_req,
    input  logic                  start_req,
    input  logic [XLEN-1:0]       start_addr_in,
    input  logic [SEL_W-1:0]      tx_sel,
    input  logic [NUM_TX_SRC-1:0] tx_in,
    output logic                  cpu_reset_n,
    output logic                  cpu_start,
    output logic [XLEN-1:0]       cpu_start_addr,
    output logic                  stack_we,
    output logic [XLEN-1:0]       stack_data,
    output logic                  TXD,
    output logic [SEL_W-1:0]      tx_active_sel,
    output logic                  boot_busy
);

    localparam logic [7:0] POR_LAST = 8'(POR_DELAY - 1);

    boot_state_t state;
    logic [7:0]  por_cnt;

    assign stack_data = DEFAULT_STACK_ADDR;

    // cpu_reset_req has top priority in every state; start pulses self-clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= POR_WAIT;
            por_cnt        <= '0;
            cpu_reset_n    <= 1'b0;
            cpu_start      <= 1'b0;
            cpu_start_addr <= '0;
            stack_we       <= 1'b0;
            boot_busy      <= 1'b1;
        end else begin
            cpu_start <= 1'b0;
            stack_we  <= 1'b0;
            if (cpu_reset_req) begin
                state       <= HOLD;
                cpu_reset_n <= 1'b0;
                boot_busy   <= 1'b1;
            end else begin
                case (state)
                    POR_WAIT: begin
                        cpu_reset_n <= 1'b1;
                        por_cnt     <= por_cnt + 8'd1;
                        if (start_req) begin
                            state          <= RUN;
                            cpu_start      <= 1'b1;
                            cpu_start_addr <= start_addr_in;
                            stack_we       <= 1'b1;
                            boot_busy      <= 1'b0;
                        end else if (por_cnt == POR_LAST) begin
                            state          <= RUN;
                            cpu_start      <= 1'b1;
                            cpu_start_addr <= DEFAULT_START_ADDR;
                            boot_busy      <= 1'b0;
                        end
                    end
                    RUN: begin
                        cpu_reset_n <= 1'b1;
                        if (start_req) begin
                            cpu_start      <= 1'b1;
                            cpu_start_addr <= start_addr_in;
                            stack_we       <= 1'b1;
                        end
                    end
                    HOLD: begin
                        // Release goes straight to RUN; the OCD issues the start itself.
                        state       <= RUN;
                        cpu_reset_n <= 1'b1;
                        boot_busy   <= 1'b0;
                    end
                    default: begin
                        state     <= POR_WAIT;
                        boot_busy <= 1'b1;
                    end
                endcase
            end
        end
    end

    uart_tx_arbiter #(
        .NUM_TX_SRC (NUM_TX_SRC),
        .SEL_W      (SEL_W),
        .IDLE_GUARD (IDLE_GUARD)
    ) u_tx_arb (
        .clk        (clk),
        .reset_n    (reset_n),
        .tx_sel     (tx_sel),
        .tx_in      (tx_in),
        .txd        (TXD),
        .active_sel (tx_active_sel)
    );

endmodule

// File: tb/tb_boot_uart_ctrl.sv
// Randomized and directed bench for boot_uart_ctrl against an event-level
// reference model of the start sequencer and the guarded TX arbiter.
module tb_boot_uart_ctrl;

    localparam int          NSRC      = 3;
    localparam int          SW        = 2;
    localparam int          XL        = 32;
    localparam int          POR_DLY   = 4;
    localparam int          GUARD     = 8;
    localparam logic [31:0] DEF_START = 32'h8000_0000;
    localparam logic [31:0] DEF_STACK = 32'h8000_FFF0;

    logic            clk;
    logic            reset_n;
    logic            cpu_reset_req;
    logic            start_req;
    logic [XL-1:0]   start_addr_in;
    logic [SW-1:0]   tx_sel;
    logic [NSRC-1:0] tx_in;
    logic            cpu_reset_n;
    logic            cpu_start;
    logic [XL-1:0]   cpu_start_addr;
    logic            stack_we;
    logic [XL-1:0]   stack_data;
    logic            TXD;
    logic [SW-1:0]   tx_active_sel;
    logic            boot_busy;

    int checks = 0;
    int passes = 0;

    // Reference model state: behaviour expressed as "cycles since release"
    // and pending/held flags rather than as a state machine.
    bit          m_rstn, m_start, m_we, m_busy, m_txd;
    bit          m_hold, m_armed;
    logic [31:0] m_addr;
    int          m_age, m_active, m_run;

    boot_uart_ctrl #(
        .NUM_TX_SRC         (NSRC),
        .SEL_W              (SW),
        .XLEN               (XL),
        .DEFAULT_START_ADDR (DEF_START),
        .DEFAULT_STACK_ADDR (DEF_STACK),
        .POR_DELAY          (POR_DLY),
        .IDLE_GUARD         (GUARD)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cpu_reset_req  (cpu_reset_req),
        .start_req      (start_req),
        .start_addr_in  (start_addr_in),
        .tx_sel         (tx_sel),
        .tx_in          (tx_in),
        .cpu_reset_n    (cpu_reset_n),
        .cpu_start      (cpu_start),
        .cpu_start_addr (cpu_start_addr),
        .stack_we       (stack_we),
        .stack_data     (stack_data),
        .TXD            (TXD),
        .tx_active_sel  (tx_active_sel),
        .boot_busy      (boot_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp)
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        else
            passes++;
    endtask

    // Advances the model by one clock edge using the inputs the DUT sampled.
    task automatic modelStep();
        if (!reset_n) begin
            m_rstn = 0; m_start = 0; m_we = 0; m_addr = '0;
            m_hold = 0; m_armed = 1; m_age = 0; m_busy = 1;
            m_txd = 1; m_active = 0; m_run = 0;
        end else begin
            bit line;
            m_age++;
            m_start = 0;
            m_we    = 0;
            if (cpu_reset_req) begin
                m_rstn = 0; m_hold = 1; m_armed = 0;
            end else if (m_hold) begin
                m_rstn = 1; m_hold = 0;
            end else begin
                m_rstn = 1;
                if (start_req) begin
                    m_start = 1; m_we = 1; m_addr = start_addr_in; m_armed = 0;
                end else if (m_armed && m_age == POR_DLY) begin
                    m_start = 1; m_addr = DEF_START; m_armed = 0;
                end
            end
            m_busy = m_hold || m_armed;

            line  = tx_in[m_active];
            m_txd = line;
            if (int'(tx_sel) != m_active && int'(tx_sel) < NSRC && m_run >= GUARD) begin
                m_active = int'(tx_sel);
                m_run    = 0;
            end else begin
                m_run = line ? m_run + 1 : 0;
            end
        end
    endtask

    task automatic compareAll();
        checkOutput("cpu_reset_n",    32'(cpu_reset_n),   32'(m_rstn));
        checkOutput("cpu_start",      32'(cpu_start),     32'(m_start));
        checkOutput("cpu_start_addr", cpu_start_addr,     m_addr);
        checkOutput("stack_we",       32'(stack_we),      32'(m_we));
        checkOutput("stack_data",     stack_data,         DEF_STACK);
        checkOutput("boot_busy",      32'(boot_busy),     32'(m_busy));
        checkOutput("TXD",            32'(TXD),           32'(m_txd));
        checkOutput("tx_active_sel",  32'(tx_active_sel), 32'(m_active));
    endtask

    task automatic applyStimulus(input logic rn, input logic rreq, input logic sreq,
                                 input logic [31:0] addr, input logic [SW-1:0] sel,
                                 input logic [NSRC-1:0] tin);
        reset_n       = rn;
        cpu_reset_req = rreq;
        start_req     = sreq;
        start_addr_in = addr;
        tx_sel        = sel;
        tx_in         = tin;
        @(posedge clk);
        modelStep();
        #1;
        compareAll();
    endtask

    task automatic idleCycles(input int n, input logic [SW-1:0] sel);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b1, 1'b0, 1'b0, $urandom, sel, '1);
    endtask

    initial begin
        logic          rreq_lvl;
        logic [SW-1:0] sel_lvl;
        logic [NSRC-1:0] tin;

        reset_n = 0; cpu_reset_req = 0; start_req = 0;
        start_addr_in = '0; tx_sel = '0; tx_in = '1;

        // Reset state, then power-on auto start on cycle POR_DLY.
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '1);
        idleCycles(8, 2'd0);

        // OCD start in RUN, then back-to-back starts.
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h8000_1234, 2'd0, '1);
        idleCycles(2, 2'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h1111_0000, 2'd0, '1);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h2222_0004, 2'd0, '1);
        idleCycles(2, 2'd0);

        // Reset hold for 10 cycles with a start attempt at cycle 3.
        for (int i = 1; i <= 10; i++)
            applyStimulus(1'b1, 1'b1, (i == 3), 32'hDEAD_BEEF, 2'd0, '1);
        idleCycles(8, 2'd0);

        // Early OCD start during the power-on wait.
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '1);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, '1);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h8000_4000, '0, '1);
        idleCycles(6, 2'd0);

        // Guarded switch: high runs of 5 never satisfy the guard, then hold idle.
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '1);
        for (int r = 0; r < 4; r++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, '0, 2'd1, 3'b110);
            for (int k = 0; k < 5; k++)
                applyStimulus(1'b1, 1'b0, 1'b0, '0, 2'd1, {1'b1, 1'($urandom_range(0, 1)), 1'b1});
        end
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 2'd1, 3'b110);
        for (int k = 0; k < 14; k++)
            applyStimulus(1'b1, 1'b0, 1'b0, '0, 2'd1, {1'b1, 1'($urandom_range(0, 1)), 1'b1});

        // Illegal select, then reset in the middle of a frame on source 1.
        idleCycles(50, 2'd3);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 2'd3, 3'b101);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 2'd3, 3'b100);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 2'd0, 3'b110);

        // Randomized traffic across both halves of the design.
        rreq_lvl = 1'b0;
        sel_lvl  = '0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) rreq_lvl = ~rreq_lvl;
            if ($urandom_range(0, 39) == 0) sel_lvl = SW'($urandom_range(0, 3));
            for (int b = 0; b < NSRC; b++) tin[b] = ($urandom_range(0, 15) != 0);
            applyStimulus(($urandom_range(0, 199) != 0), rreq_lvl,
                          ($urandom_range(0, 7) == 0), $urandom, sel_lvl, tin);
        end

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
